// File: rtl/axis_histogram_ctrl.sv
// Acquisition sequencer in front of the AXI-Stream histogram core: clears the
// histogram BRAM, forwards a fixed number of beats, waits for the last update.
module axis_histogram_ctrl #(
  parameter int unsigned AXIS_TDATA_WIDTH = 16,
  parameter int unsigned BRAM_DATA_WIDTH  = 32,
  parameter int unsigned BRAM_ADDR_WIDTH  = 14,
  parameter int unsigned CNTR_WIDTH       = 32
) (
  input  logic                         aclk,
  input  logic                         areset,

  input  logic                         cfg_start,
  input  logic [CNTR_WIDTH-1:0]        cfg_samples,
  output logic                         sts_busy,
  output logic                         sts_done,
  output logic [CNTR_WIDTH-1:0]        sts_count,

  input  logic [AXIS_TDATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,

  output logic [AXIS_TDATA_WIDTH-1:0]  m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,

  input  logic                         h_bram_en,
  input  logic [BRAM_DATA_WIDTH/8-1:0] h_bram_we,
  input  logic [BRAM_ADDR_WIDTH-1:0]   h_bram_addr,
  input  logic [BRAM_DATA_WIDTH-1:0]   h_bram_wdata,
  output logic [BRAM_DATA_WIDTH-1:0]   h_bram_rdata,

  output logic                         b_bram_clk,
  output logic                         b_bram_rst,
  output logic                         b_bram_en,
  output logic [BRAM_DATA_WIDTH/8-1:0] b_bram_we,
  output logic [BRAM_ADDR_WIDTH-1:0]   b_bram_addr,
  output logic [BRAM_DATA_WIDTH-1:0]   b_bram_wdata,
  input  logic [BRAM_DATA_WIDTH-1:0]   b_bram_rdata
);

  localparam logic [BRAM_ADDR_WIDTH-1:0] AddrOne = BRAM_ADDR_WIDTH'(1);
  localparam logic [CNTR_WIDTH-1:0]      CntOne  = CNTR_WIDTH'(1);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRun,
    StDrain,
    StDone
  } state_e;

  state_e                       state_q, state_d;
  logic [BRAM_ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
  logic [CNTR_WIDTH-1:0]        cnt_q, cnt_d;
  logic [CNTR_WIDTH-1:0]        samples_q, samples_d;
  logic [1:0]                   drain_q, drain_d;
  logic                         clear_sel;
  logic                         beat;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= StIdle;
      clr_addr_q <= '0;
      cnt_q      <= '0;
      samples_q  <= '0;
      drain_q    <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      cnt_q      <= cnt_d;
      samples_q  <= samples_d;
      drain_q    <= drain_d;
    end
  end

  assign beat = s_axis_tvalid & m_axis_tready;

  always_comb begin
    state_d       = state_q;
    clr_addr_d    = clr_addr_q;
    cnt_d         = cnt_q;
    samples_d     = samples_q;
    drain_d       = drain_q;
    clear_sel     = 1'b0;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (cfg_start) begin
          samples_d  = cfg_samples;
          clr_addr_d = '0;
          cnt_d      = '0;
          state_d    = StClear;
        end
      end
      StClear: begin
        clear_sel  = 1'b1;
        clr_addr_d = clr_addr_q + AddrOne;
        if (clr_addr_q == '1) begin
          state_d = (samples_q == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
        if (beat) begin
          cnt_d = cnt_q + CntOne;
          // Last beat: leave RUN at this edge so nothing further is accepted.
          if (cnt_q == samples_q - CntOne) begin
            state_d = StDrain;
            drain_d = '0;
          end
        end
      end
      StDrain: begin
        // Four cycles cover the core's three-cycle read-modify-write.
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'd3) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign m_axis_tdata = s_axis_tdata;

  assign sts_busy  = (state_q == StClear) || (state_q == StRun) || (state_q == StDrain);
  assign sts_done  = (state_q == StDone);
  assign sts_count = cnt_q;

  assign b_bram_clk   = aclk;
  assign b_bram_rst   = areset;
  assign b_bram_en    = clear_sel ? 1'b1 : h_bram_en;
  assign b_bram_we    = clear_sel ? {(BRAM_DATA_WIDTH/8){1'b1}} : h_bram_we;
  assign b_bram_addr  = clear_sel ? clr_addr_q : h_bram_addr;
  assign b_bram_wdata = clear_sel ? '0 : h_bram_wdata;
  assign h_bram_rdata = b_bram_rdata;

endmodule

// File: tb/tb_axis_histogram_ctrl.sv
// Directed bench for axis_histogram_ctrl with a BRAM model, a 3-cycle
// histogram core model and a scoreboard of forwarded beats.
module tb_axis_histogram_ctrl;

  localparam int unsigned TW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned CW = 32;

  logic          aclk = 1'b0;
  logic          areset;
  logic          cfg_start;
  logic [CW-1:0] cfg_samples;
  logic          sts_busy, sts_done;
  logic [CW-1:0] sts_count;
  logic [TW-1:0] s_axis_tdata, m_axis_tdata;
  logic          s_axis_tvalid, s_axis_tready, m_axis_tvalid, m_axis_tready;
  logic          h_bram_en, b_bram_en, b_bram_clk, b_bram_rst;
  logic [DW/8-1:0] h_bram_we, b_bram_we;
  logic [AW-1:0] h_bram_addr, b_bram_addr;
  logic [DW-1:0] h_bram_wdata, h_bram_rdata, b_bram_wdata, b_bram_rdata;

  int n_chk = 0;
  int n_fail = 0;

  logic [DW-1:0] mem [16];
  logic          bram_fill;
  logic [1:0]    core_stg;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_val;
  logic          tog_en;
  logic [1:0]    tog_ph;
  logic [3:0]    tog_pat = 4'b1001;
  logic          mirror_win;
  int            mirror_bad = 0;
  int            mirror_seen = 0;
  int            fwd_beats = 0;
  int            mvalid_cycles = 0;
  logic [TW-1:0] exp_q [$];

  axis_histogram_ctrl #(
    .AXIS_TDATA_WIDTH(TW),
    .BRAM_DATA_WIDTH (DW),
    .BRAM_ADDR_WIDTH (AW),
    .CNTR_WIDTH      (CW)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .cfg_start    (cfg_start),
    .cfg_samples  (cfg_samples),
    .sts_busy     (sts_busy),
    .sts_done     (sts_done),
    .sts_count    (sts_count),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .h_bram_en    (h_bram_en),
    .h_bram_we    (h_bram_we),
    .h_bram_addr  (h_bram_addr),
    .h_bram_wdata (h_bram_wdata),
    .h_bram_rdata (h_bram_rdata),
    .b_bram_clk   (b_bram_clk),
    .b_bram_rst   (b_bram_rst),
    .b_bram_en    (b_bram_en),
    .b_bram_we    (b_bram_we),
    .b_bram_addr  (b_bram_addr),
    .b_bram_wdata (b_bram_wdata),
    .b_bram_rdata (b_bram_rdata)
  );

  always #5 aclk = ~aclk;

  // Read-first BRAM with full-word write enable.
  always @(posedge b_bram_clk) begin
    if (bram_fill) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hFFFF_FFFF;
    end else if (b_bram_en) begin
      if (b_bram_we == 4'hF) mem[b_bram_addr] <= b_bram_wdata;
      b_bram_rdata <= mem[b_bram_addr];
    end
  end

  // Histogram core: accept, read, wait, write back +1; not ready while busy.
  always @(posedge aclk) begin
    if (areset) begin
      core_stg <= 2'd0;
      tog_ph   <= 2'd0;
    end else begin
      tog_ph <= tog_ph + 2'd1;
      case (core_stg)
        2'd0: if (m_axis_tvalid && m_axis_tready) begin
          core_addr <= m_axis_tdata[AW-1:0];
          core_stg  <= 2'd1;
        end
        2'd1: core_stg <= 2'd2;
        2'd2: begin
          core_val <= h_bram_rdata + 32'd1;
          core_stg <= 2'd3;
        end
        default: core_stg <= 2'd0;
      endcase
    end
  end

  assign m_axis_tready = (core_stg == 2'd0) && (tog_en ? tog_pat[tog_ph] : 1'b1);
  assign h_bram_en     = (core_stg == 2'd1) || (core_stg == 2'd3);
  assign h_bram_we     = (core_stg == 2'd3) ? 4'hF : 4'h0;
  assign h_bram_addr   = core_addr;
  assign h_bram_wdata  = core_val;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard pop on every forwarded beat, sampled mid-cycle.
  always @(negedge aclk) begin
    #2;
    if (m_axis_tvalid) mvalid_cycles++;
    if (mirror_win) begin
      mirror_seen++;
      if (s_axis_tready !== m_axis_tready) mirror_bad++;
    end
    if (m_axis_tvalid && m_axis_tready) begin
      fwd_beats++;
      check("fwd_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("fwd_data", m_axis_tdata, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  // Caller is at a negedge; returns at the negedge after the accepting edge.
  task automatic do_start(input int unsigned n);
    cfg_samples = n;
    cfg_start   = 1'b1;
    @(negedge aclk);
    cfg_start   = 1'b0;
  endtask

  task automatic send_beat(input logic [TW-1:0] d);
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      #1;
      if (s_axis_tready) begin
        exp_q.push_back(d);
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        return;
      end
      @(negedge aclk);
    end
    check("beat_accept_timeout", 64'd0, 64'd1);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 0; k < 64; k++) begin
      #1;
      if (sts_done) begin
        @(negedge aclk);
        return;
      end
      lat++;
      @(negedge aclk);
    end
    check("done_timeout", 64'd0, 64'd1);
  endtask

  function automatic int nonzero_bins();
    int n = 0;
    for (int i = 0; i < 16; i++) if (mem[i] != 0) n++;
    return n;
  endfunction

  initial begin
    int lat, fwd0, mv0;
    areset = 1'b1; cfg_start = 1'b0; cfg_samples = '0; bram_fill = 1'b1;
    s_axis_tvalid = 1'b1; s_axis_tdata = 16'h2; tog_en = 1'b0; mirror_win = 1'b0;
    repeat (3) @(negedge aclk);
    #1;
    check("rst_busy", sts_busy, 1'b0);
    check("rst_done", sts_done, 1'b0);
    check("rst_count", sts_count, 0);
    check("rst_s_tready", s_axis_tready, 1'b0);
    check("rst_m_tvalid", m_axis_tvalid, 1'b0);
    @(negedge aclk);
    areset = 1'b0; bram_fill = 1'b0; s_axis_tvalid = 1'b0;

    // Clear sweep over a preloaded BRAM, then 3 beats.
    do_start(3);
    for (int i = 0; i < 16; i++) begin
      #1;
      check("clr_en", b_bram_en, 1'b1);
      check("clr_we", b_bram_we, 4'hF);
      check("clr_addr", b_bram_addr, i);
      check("clr_wdata", b_bram_wdata, 0);
      @(negedge aclk);
    end
    check("clr_zeroed", nonzero_bins(), 0);
    check("run_busy", sts_busy, 1'b1);
    send_beat(16'd1); send_beat(16'd1); send_beat(16'd5);
    wait_done(lat);
    check("t1_count", sts_count, 3);
    check("t1_bin1", mem[1], 2);
    check("t1_bin5", mem[5], 1);

    // Five beats of 2,2,7,2,9 with a sixth offered that must not pass.
    do_start(5);
    repeat (16) @(negedge aclk);
    fwd0 = fwd_beats;
    send_beat(16'd2); send_beat(16'd2); send_beat(16'd7); send_beat(16'd2); send_beat(16'd9);
    s_axis_tdata = 16'd3; s_axis_tvalid = 1'b1;
    wait_done(lat);
    check("t2_drain_cycles", lat, 4);
    #1;
    check("t2_done_s_tready", s_axis_tready, 1'b0);
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    check("t2_fwd", fwd_beats - fwd0, 5);
    check("t2_count", sts_count, 5);
    check("t2_bin2", mem[2], 3);
    check("t2_bin7", mem[7], 1);
    check("t2_bin9", mem[9], 1);
    check("t2_others", nonzero_bins(), 3);

    // Zero samples: straight from CLEAR to DONE, stream never opened.
    mv0 = mvalid_cycles;
    s_axis_tvalid = 1'b1; s_axis_tdata = 16'd4;
    do_start(0);
    repeat (15) @(negedge aclk);
    #1;
    check("t3_last_clear_busy", sts_busy, 1'b1);
    @(negedge aclk);
    #1;
    check("t3_done", sts_done, 1'b1);
    check("t3_busy", sts_busy, 1'b0);
    check("t3_count", sts_count, 0);
    check("t3_mvalid", mvalid_cycles - mv0, 0);
    @(negedge aclk);
    s_axis_tvalid = 1'b0;

    // Toggling core ready, source gaps, ignored restarts with samples=9.
    tog_en = 1'b1;
    fwd0 = fwd_beats;
    do_start(4);
    repeat (5) @(negedge aclk);
    cfg_samples = 9; cfg_start = 1'b1;
    @(negedge aclk);
    cfg_start = 1'b0;
    repeat (10) @(negedge aclk);
    mirror_win = 1'b1;
    send_beat(16'd11);
    @(negedge aclk);
    cfg_start = 1'b1;
    @(negedge aclk);
    cfg_start = 1'b0;
    send_beat(16'd12);
    send_beat(16'd13);
    @(negedge aclk);
    send_beat(16'd14);
    mirror_win = 1'b0;
    wait_done(lat);
    check("t4_count", sts_count, 4);
    check("t4_fwd", fwd_beats - fwd0, 4);
    check("t4_sb_empty", exp_q.size(), 0);
    check("t4_mirror_bad", mirror_bad, 0);
    check("t4_mirror_seen", 64'(mirror_seen > 8), 64'd1);
    check("t4_bin11", mem[11], 1);
    check("t4_bin14", mem[14], 1);
    tog_en = 1'b0;

    // Reset in the middle of the clear sweep, then restart.
    do_start(2);
    repeat (6) @(negedge aclk);
    #1;
    check("t6_addr6", b_bram_addr, 6);
    areset = 1'b1;
    @(negedge aclk);
    #1;
    check("t6_busy", sts_busy, 1'b0);
    check("t6_done", sts_done, 1'b0);
    check("t6_count", sts_count, 0);
    check("t6_bram_en", b_bram_en, 1'b0);
    check("t6_s_tready", s_axis_tready, 1'b0);
    @(negedge aclk);
    areset = 1'b0;
    do_start(2);
    #1;
    check("t6_restart_busy", sts_busy, 1'b1);
    check("t6_restart_addr", b_bram_addr, 0);
    check("t6_restart_en", b_bram_en, 1'b1);
    @(negedge aclk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
